// File: rtl/i2c_txn_arbiter_if.sv
// ---------------------------------------------------------------------------
// i2c_txn_arbiter_if
// Bundle between the transaction arbiter and the shared I2C master core.
//   m_addr                 7  slave address presented to the master
//   m_data_in              8  write byte presented to the master
//   m_rw                   1  0 = write, 1 = read
//   m_enable               1  launch strobe, held high for the launch window
//   m_clock_stretch_delay  8  clock stretch setting for the transaction
//   m_data_out             8  read byte returned by the master
//   m_ready                1  master idle when high
// Modports:
//   master : the arbiter side (drives the command, observes status)
//   slave  : the I2C master core side (observes command, drives status)
// ---------------------------------------------------------------------------
interface i2c_txn_arbiter_if;
  logic [6:0] m_addr;
  logic [7:0] m_data_in;
  logic       m_rw;
  logic       m_enable;
  logic [7:0] m_clock_stretch_delay;
  logic [7:0] m_data_out;
  logic       m_ready;

  modport master (
    output m_addr,
    output m_data_in,
    output m_rw,
    output m_enable,
    output m_clock_stretch_delay,
    input  m_data_out,
    input  m_ready
  );

  modport slave (
    input  m_addr,
    input  m_data_in,
    input  m_rw,
    input  m_enable,
    input  m_clock_stretch_delay,
    output m_data_out,
    output m_ready
  );
endinterface

// File: rtl/i2c_txn_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_txn_arbiter
// Shares one I2C master core between two requesters. A request is granted
// round-robin while the master is idle, its command is latched onto the
// master bus, m_enable is strobed for EN_CYCLES clocks, and the arbiter then
// waits for the master to go busy and come back idle (or for TIMEOUT clocks)
// before pulsing the granted requester's done.
// Parameters:
//   EN_CYCLES  clocks m_enable is held high per launch
//   TIMEOUT    max clocks from end of launch to transaction end
// Ports:
//   clk, rst                   clock (rising edge), async active-low reset
//   reqN/addrN/wdataN/rwN/stretchN   requester N command (N = 0, 1)
//   doneN/rdataN/errN          requester N completion pulse, read data,
//                              timeout flag (only alongside done)
//   busy                       high whenever the FSM is not idle
//   bus                        master-core command/status bundle
// ---------------------------------------------------------------------------
module i2c_txn_arbiter #(
  parameter int EN_CYCLES = 10,
  parameter int TIMEOUT   = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [6:0] addr0,
  input  logic [6:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  input  logic       rw0,
  input  logic       rw1,
  input  logic [7:0] stretch0,
  input  logic [7:0] stretch1,
  output logic       done0,
  output logic       done1,
  output logic [7:0] rdata0,
  output logic [7:0] rdata1,
  output logic       err0,
  output logic       err1,
  output logic       busy,
  i2c_txn_arbiter_if.master bus
);

  localparam int EW = (EN_CYCLES > 1) ? $clog2(EN_CYCLES) : 1;
  // Counter holds values 0..TIMEOUT inclusive and never wraps.
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [EW-1:0] EN_LAST = EW'(EN_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LAUNCH    = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_COMPLETE  = 3'd4
  } state_t;

  state_t        state_r;
  logic [EW-1:0] en_cnt_r;
  logic [TW-1:0] tcnt_r;
  logic          seen_busy_r;
  logic          gnt_r;   // requester owning the current transaction
  logic          prio_r;  // requester that wins a tie
  logic          gnt_s;

  // Round-robin pick: on a tie the priority pointer decides.
  always_comb begin
    gnt_s = 1'b0;
    if (req0 && req1) begin
      gnt_s = prio_r;
    end else if (req1) begin
      gnt_s = 1'b1;
    end else begin
      gnt_s = 1'b0;
    end
  end

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r                   <= ST_IDLE;
      en_cnt_r                  <= {EW{1'b0}};
      tcnt_r                    <= {TW{1'b0}};
      seen_busy_r               <= 1'b0;
      gnt_r                     <= 1'b0;
      prio_r                    <= 1'b0;
      busy                      <= 1'b0;
      done0                     <= 1'b0;
      done1                     <= 1'b0;
      err0                      <= 1'b0;
      err1                      <= 1'b0;
      rdata0                    <= 8'h00;
      rdata1                    <= 8'h00;
      bus.m_addr                <= 7'h00;
      bus.m_data_in             <= 8'h00;
      bus.m_rw                  <= 1'b0;
      bus.m_enable              <= 1'b0;
      bus.m_clock_stretch_delay <= 8'h00;
    end else begin
      // done/err are single-cycle pulses unless re-asserted below.
      done0 <= 1'b0;
      done1 <= 1'b0;
      err0  <= 1'b0;
      err1  <= 1'b0;

      case (state_r)
        ST_IDLE: begin
          if ((req0 || req1) && bus.m_ready) begin
            gnt_r                     <= gnt_s;
            prio_r                    <= ~gnt_s;
            bus.m_addr                <= gnt_s ? addr1    : addr0;
            bus.m_data_in             <= gnt_s ? wdata1   : wdata0;
            bus.m_rw                  <= gnt_s ? rw1      : rw0;
            bus.m_clock_stretch_delay <= gnt_s ? stretch1 : stretch0;
            bus.m_enable              <= 1'b1;
            en_cnt_r                  <= {EW{1'b0}};
            seen_busy_r               <= 1'b0;
            busy                      <= 1'b1;
            state_r                   <= ST_LAUNCH;
          end
        end

        ST_LAUNCH: begin
          if (!bus.m_ready) begin
            seen_busy_r <= 1'b1;
          end
          if (en_cnt_r == EN_LAST) begin
            bus.m_enable <= 1'b0;
            tcnt_r       <= {TW{1'b0}};
            // A busy master seen in the final launch cycle also counts.
            state_r      <= (seen_busy_r || !bus.m_ready) ? ST_WAIT_DONE
                                                          : ST_WAIT_BUSY;
          end else begin
            en_cnt_r <= en_cnt_r + EW'(1);
          end
        end

        ST_WAIT_BUSY: begin
          if (tcnt_r == TO_LAST) begin
            state_r <= ST_COMPLETE;
            if (gnt_r) begin
              done1  <= 1'b1;
              err1   <= 1'b1;
              rdata1 <= 8'h00;
            end else begin
              done0  <= 1'b1;
              err0   <= 1'b1;
              rdata0 <= 8'h00;
            end
          end else begin
            tcnt_r <= tcnt_r + TW'(1);
            if (!bus.m_ready) begin
              state_r <= ST_WAIT_DONE;
            end
          end
        end

        ST_WAIT_DONE: begin
          // Normal completion is checked first so it wins over a timeout
          // landing in the same cycle.
          if (bus.m_ready) begin
            state_r <= ST_COMPLETE;
            if (gnt_r) begin
              done1 <= 1'b1;
              if (bus.m_rw) begin
                rdata1 <= bus.m_data_out;
              end
            end else begin
              done0 <= 1'b1;
              if (bus.m_rw) begin
                rdata0 <= bus.m_data_out;
              end
            end
          end else if (tcnt_r == TO_LAST) begin
            state_r <= ST_COMPLETE;
            if (gnt_r) begin
              done1  <= 1'b1;
              err1   <= 1'b1;
              rdata1 <= 8'h00;
            end else begin
              done0  <= 1'b1;
              err0   <= 1'b1;
              rdata0 <= 8'h00;
            end
          end else begin
            tcnt_r <= tcnt_r + TW'(1);
          end
        end

        ST_COMPLETE: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end

        default: begin
          busy         <= 1'b0;
          bus.m_enable <= 1'b0;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// ---------------------------------------------------------------------------
// tb_i2c_txn_arbiter
// Directed and randomized transactions against i2c_txn_arbiter. A scripted
// master core (ready drops d cycles after grant for b cycles; b = 0 means it
// never goes busy) is driven cycle by cycle, and the expected grant owner,
// completion cycle, err and rdata are derived arithmetically from that script.
// ---------------------------------------------------------------------------
module tb_i2c_txn_arbiter;
  localparam int EN = 10;
  localparam int TO = 40;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [6:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       rw0, rw1;
  logic [7:0] stretch0, stretch1;
  logic       done0, done1;
  logic [7:0] rdata0, rdata1;
  logic       err0, err1;
  logic       busy;

  i2c_txn_arbiter_if bus();

  i2c_txn_arbiter #(.EN_CYCLES(EN), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .rw0(rw0), .rw1(rw1),
    .stretch0(stretch0), .stretch1(stretch1),
    .done0(done0), .done1(done1),
    .rdata0(rdata0), .rdata1(rdata1),
    .err0(err0), .err1(err1),
    .busy(busy),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int         nvec = 0;
  int         nerr = 0;
  bit         prio = 1'b0;          // requester that wins a tie
  logic [7:0] rdata_exp [2];
  bit   [1:0] rp;
  int         dd, bb, sel;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"},    32'(busy), 32'd0);
    check({tag, "_enable"},  32'(bus.m_enable), 32'd0);
    check({tag, "_done0"},   32'(done0), 32'd0);
    check({tag, "_done1"},   32'(done1), 32'd0);
    check({tag, "_err0"},    32'(err0), 32'd0);
    check({tag, "_err1"},    32'(err1), 32'd0);
    check({tag, "_rdata0"},  32'(rdata0), 32'd0);
    check({tag, "_rdata1"},  32'(rdata1), 32'd0);
    check({tag, "_addr"},    32'(bus.m_addr), 32'd0);
    check({tag, "_din"},     32'(bus.m_data_in), 32'd0);
    check({tag, "_rw"},      32'(bus.m_rw), 32'd0);
    check({tag, "_stretch"}, 32'(bus.m_clock_stretch_delay), 32'd0);
  endtask

  // One transaction. k counts samples taken #1 after each edge, k = 0 being
  // the grant edge. Master ready is low for k in [d, d+b).
  task automatic do_txn(input bit r0, input bit r1, input bit rw,
                        input logic [6:0] ad, input logic [7:0] wd,
                        input logic [7:0] st, input int d, input int b,
                        input logic [7:0] rv, input int hold,
                        input bit drop, input int rst_at);
    bit         w, to, aborted;
    int         k_norm, k_lim, k_done;
    logic [7:0] rd_new;
    w       = (r0 && r1) ? prio : r1;
    k_lim   = EN + 1 + TO;
    // Completion needs the launch to be over and the busy period to be over.
    k_norm  = (d + b + 1 > EN + 1) ? d + b + 1 : EN + 1;
    to      = (b == 0) || (k_norm > k_lim);
    k_done  = to ? k_lim : k_norm;
    rd_new  = to ? 8'h00 : (rw ? rv : rdata_exp[w]);
    aborted = 1'b0;

    req0 = r0;
    req1 = r1;
    if (w) begin
      addr1 = ad; wdata1 = wd; rw1 = rw; stretch1 = st;
      addr0 = 7'($urandom); wdata0 = 8'($urandom); rw0 = 1'($urandom); stretch0 = 8'($urandom);
    end else begin
      addr0 = ad; wdata0 = wd; rw0 = rw; stretch0 = st;
      addr1 = 7'($urandom); wdata1 = 8'($urandom); rw1 = 1'($urandom); stretch1 = 8'($urandom);
    end

    bus.m_ready = (hold > 0) ? 1'b0 : 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_busy", 32'(busy), 32'd0);
      check("hold_enable", 32'(bus.m_enable), 32'd0);
    end
    bus.m_ready = 1'b1;
    bus.m_data_out = 8'($urandom);

    for (int k = 0; k <= k_done; k++) begin
      @(posedge clk); #1;
      if (k == rst_at) begin
        rst = 1'b0; #1;
        check_reset_state("midrst");
        prio = 1'b0;
        rdata_exp[0] = 8'h00;
        rdata_exp[1] = 8'h00;
        req0 = 1'b0; req1 = 1'b0; bus.m_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        aborted = 1'b1;
        break;
      end
      check("enable", 32'(bus.m_enable), 32'(k < EN));
      check("busy", 32'(busy), 32'd1);
      check("m_addr", 32'(bus.m_addr), 32'(ad));
      check("m_data_in", 32'(bus.m_data_in), 32'(wd));
      check("m_rw", 32'(bus.m_rw), 32'(rw));
      check("m_stretch", 32'(bus.m_clock_stretch_delay), 32'(st));
      check(w ? "done1" : "done0", 32'(w ? done1 : done0), 32'(k == k_done));
      check(w ? "err1" : "err0", 32'(w ? err1 : err0), 32'(k == k_done && to));
      check(w ? "done0_idle" : "done1_idle", 32'(w ? done0 : done1), 32'd0);
      check(w ? "err0_idle" : "err1_idle", 32'(w ? err0 : err1), 32'd0);
      check(w ? "rdata1" : "rdata0", 32'(w ? rdata1 : rdata0),
            32'((k == k_done) ? rd_new : rdata_exp[w]));
      check(w ? "rdata0_hold" : "rdata1_hold", 32'(w ? rdata0 : rdata1), 32'(rdata_exp[!w]));

      if (k == 1) begin
        if (w) begin
          addr1 = 7'($urandom); wdata1 = 8'($urandom); rw1 = 1'($urandom); stretch1 = 8'($urandom);
        end else begin
          addr0 = 7'($urandom); wdata0 = 8'($urandom); rw0 = 1'($urandom); stretch0 = 8'($urandom);
        end
      end
      if (k == 2 && drop) begin
        if (w) req1 = 1'b0; else req0 = 1'b0;
      end
      bus.m_ready    = !(b > 0 && k >= d && k < d + b);
      bus.m_data_out = (b > 0 && k >= d + b) ? rv : 8'($urandom);
      if (k == k_done) begin
        if (w) req1 = 1'b0; else req0 = 1'b0;
        bus.m_ready = 1'b1;
      end
    end

    if (!aborted) begin
      rdata_exp[w] = rd_new;
      prio = !w;
      @(posedge clk); #1;
      check("post_busy", 32'(busy), 32'd0);
      check("post_enable", 32'(bus.m_enable), 32'd0);
      check("post_done0", 32'(done0), 32'd0);
      check("post_done1", 32'(done1), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    addr0 = 7'h00; addr1 = 7'h00; wdata0 = 8'h00; wdata1 = 8'h00;
    rw0 = 1'b0; rw1 = 1'b0; stretch0 = 8'h00; stretch1 = 8'h00;
    bus.m_ready = 1'b1; bus.m_data_out = 8'h00;
    rdata_exp[0] = 8'h00; rdata_exp[1] = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    check_reset_state("rst");
    rst = 1'b1;
    @(posedge clk); #1;
    check("idle_busy", 32'(busy), 32'd0);

    // Simultaneous requests: 0 first, then 1, then 0 again on a re-raise.
    do_txn(1'b1, 1'b1, 1'b0, 7'h11, 8'h01, 8'd3, 14, 4, 8'h00, 0, 1'b0, -1);
    do_txn(1'b0, 1'b1, 1'b0, 7'h22, 8'h02, 8'd4, 13, 5, 8'h00, 0, 1'b0, -1);
    do_txn(1'b1, 1'b1, 1'b1, 7'h33, 8'h03, 8'd5, 3, 12, 8'hE1, 0, 1'b0, -1);
    do_txn(1'b1, 1'b1, 1'b1, 7'h44, 8'h04, 8'd6, 3, 12, 8'hE2, 0, 1'b0, -1);

    // Write from requester 0, master busy 5 cycles after enable.
    do_txn(1'b1, 1'b0, 1'b0, 7'h2A, 8'hAA, 8'd10, 5, 20, 8'h00, 0, 1'b0, -1);
    // Read from requester 1 returning 0x5C with stretch 50.
    do_txn(1'b0, 1'b1, 1'b1, 7'h2A, 8'h00, 8'd50, 12, 8, 8'h5C, 0, 1'b0, -1);
    // Read then a timed-out read on requester 0: rdata forced to zero.
    do_txn(1'b1, 1'b0, 1'b1, 7'h10, 8'h00, 8'd1, 4, 9, 8'h77, 0, 1'b0, -1);
    do_txn(1'b1, 1'b0, 1'b1, 7'h10, 8'h00, 8'd1, 0, 0, 8'h99, 0, 1'b0, -1);
    // Ready and timeout in the same cycle: completion wins; one later: timeout.
    do_txn(1'b1, 1'b0, 1'b1, 7'h15, 8'h00, 8'd2, 15, EN + TO - 15, 8'h3C, 0, 1'b0, -1);
    do_txn(1'b0, 1'b1, 1'b1, 7'h16, 8'h00, 8'd2, 15, EN + TO - 14, 8'h3D, 0, 1'b0, -1);
    // Busy first seen on the last timeout cycle of the busy wait, and one earlier.
    do_txn(1'b1, 1'b0, 1'b0, 7'h17, 8'h55, 8'd2, EN + TO, 1, 8'h00, 0, 1'b0, -1);
    do_txn(1'b1, 1'b0, 1'b1, 7'h18, 8'h00, 8'd2, EN + TO - 1, 1, 8'h4B, 0, 1'b0, -1);
    // Busy only in the final launch cycle.
    do_txn(1'b0, 1'b1, 1'b1, 7'h19, 8'h00, 8'd2, EN - 1, 1, 8'hB4, 0, 1'b0, -1);
    // Master not ready in idle holds off the grant; request dropped mid-way.
    do_txn(1'b1, 1'b0, 1'b0, 7'h1A, 8'h66, 8'd7, 11, 3, 8'h00, 4, 1'b1, -1);
    // Reset during the done wait aborts silently; next request is normal.
    do_txn(1'b1, 1'b0, 1'b1, 7'h1B, 8'h00, 8'd9, 2, 200, 8'hAB, 0, 1'b0, EN + 5);
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      check("after_rst_done0", 32'(done0), 32'd0);
      check("after_rst_done1", 32'(done1), 32'd0);
      check("after_rst_busy", 32'(busy), 32'd0);
    end
    do_txn(1'b1, 1'b0, 1'b1, 7'h1C, 8'h00, 8'd9, 6, 7, 8'hCD, 0, 1'b0, -1);

    for (int i = 0; i < 40; i++) begin
      rp  = 2'($urandom_range(1, 3));
      dd  = int'($urandom_range(0, 20));
      sel = int'($urandom_range(0, 9));
      if (sel == 0) bb = 0;
      else if (sel == 1) bb = EN + TO - dd + int'($urandom_range(0, 1));
      else bb = int'($urandom_range(1, 25));
      do_txn(rp[0], rp[1], 1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom),
             dd, bb, 8'($urandom), int'($urandom_range(0, 2)),
             ($urandom_range(0, 3) == 0), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
